mcp_rx_stream_fifo: RTL and testbench

Receive-side consumer that sits directly downstream of the toggle-based multi-cycle-path CDC, in the destination clock domain. It captures each DATA_I word on its single-cycle SYNC_I pulse into a small first-word-fall-through FIFO. Words leave on a valid/ready stream toward the trace buffer read logic, which may stall. Overflow is flagged rather than back-pressured, because the CDC has no acknowledge path.

---
 rtl/mcp_rx_pkg.sv | 15 +
 rtl/mcp_rx_ram.sv | 35 +++
 rtl/mcp_rx_stream_fifo.sv | 138 +++++++++++++
 tb/tb_mcp_rx_stream_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mcp_rx_pkg.sv
// rtl/mcp_rx_pkg.sv - shared types, constants and helpers for the MCP receive FIFO
package mcp_rx_pkg;

    // Width of the optional dropped-word counter.
    localparam int DROP_CNT_W = 16;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Pointer width for a FIFO of the given depth: one extra bit beyond the
    // address so that full and empty can be told apart when addresses match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mcp_rx_ram.sv
// rtl/mcp_rx_ram.sv - generic storage array with one write port and an asynchronous read
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
//
// The array is deliberately not reset; the owner masks its output when the
// FIFO is empty, so stale contents are never visible.
module mcp_rx_ram #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mcp_rx_stream_fifo.sv
// rtl/mcp_rx_stream_fifo.sv - first-word-fall-through FIFO capturing CDC words on a sync pulse
//
// Ports:
//   CLK_I       - destination-domain clock
//   RST_NI      - asynchronous active-low reset
//   DATA_I      - word from the CDC, meaningful only while SYNC_I = 1
//   SYNC_I      - single-cycle capture pulse; each high cycle captures one word
//   CLEAR_I     - synchronous flush, wins over push and pop
//   DATA_O      - head-of-FIFO word, 0 when empty
//   VALID_O     - FIFO non-empty
//   READY_I     - consumer accepts DATA_O when VALID_O = 1
//   COUNT_O     - occupancy, 0..DEPTH
//   OVERFLOW_O  - sticky, set when a word was dropped
//   DROP_CNT_O  - saturating dropped-word count (only with MCP_RX_DROP_CNT_EN)
//
// Optional feature macro: MCP_RX_DROP_CNT_EN
module mcp_rx_stream_fifo
    import mcp_rx_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                   CLK_I,
    input  logic                   RST_NI,
    input  logic [WIDTH-1:0]       DATA_I,
    input  logic                   SYNC_I,
    input  logic                   CLEAR_I,
    output logic [WIDTH-1:0]       DATA_O,
    output logic                   VALID_O,
    input  logic                   READY_I,
    output logic [$clog2(DEPTH):0] COUNT_O,
    output logic                   OVERFLOW_O
`ifdef MCP_RX_DROP_CNT_EN
    ,
    output drop_cnt_t              DROP_CNT_O
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] ram_rdata;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the head slot in the same edge, so a full FIFO can still
    // take a word when the consumer is reading. The CDC cannot be stalled,
    // hence anything else arriving while full is dropped and flagged.
    assign pop  = !empty && READY_I;
    assign push = SYNC_I && (!full || pop);
    assign drop = SYNC_I && full && !pop && !CLEAR_I;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (CLEAR_I) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    mcp_rx_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (CLK_I),
        .we    (push && !CLEAR_I),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (DATA_I),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Outputs come only from registered pointers and the array, never from
    // SYNC_I or READY_I; masking keeps unreset storage from leaking out.
    assign VALID_O    = !empty;
    assign DATA_O     = empty ? '0 : ram_rdata;
    assign COUNT_O    = wr_ptr_q - rd_ptr_q;
    assign OVERFLOW_O = overflow_q;

`ifdef MCP_RX_DROP_CNT_EN
    drop_cnt_t drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (CLEAR_I) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + drop_cnt_t'(1);
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT_O = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mcp_rx_stream_fifo.sv
// tb/tb_mcp_rx_stream_fifo.sv - directed scoreboard bench for mcp_rx_stream_fifo
module tb_mcp_rx_stream_fifo;
    import mcp_rx_pkg::*;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;

    logic             CLK_I;
    logic             RST_NI;
    logic [WIDTH-1:0] DATA_I;
    logic             SYNC_I;
    logic             CLEAR_I;
    logic [WIDTH-1:0] DATA_O;
    logic             VALID_O;
    logic             READY_I;
    logic [$clog2(DEPTH):0] COUNT_O;
    logic             OVERFLOW_O;
`ifdef MCP_RX_DROP_CNT_EN
    drop_cnt_t        DROP_CNT_O;
`endif

    mcp_rx_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_NI     (RST_NI),
        .DATA_I     (DATA_I),
        .SYNC_I     (SYNC_I),
        .CLEAR_I    (CLEAR_I),
        .DATA_O     (DATA_O),
        .VALID_O    (VALID_O),
        .READY_I    (READY_I),
        .COUNT_O    (COUNT_O),
        .OVERFLOW_O (OVERFLOW_O)
`ifdef MCP_RX_DROP_CNT_EN
        ,
        .DROP_CNT_O (DROP_CNT_O)
`endif
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] sb[$];
    logic             ovf_m;
    int               drop_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [31:0] head;
        head = (sb.size() != 0) ? 32'(sb[0]) : 32'd0;
        chk({tag, "_valid"}, 32'(VALID_O), 32'(sb.size() != 0));
        chk({tag, "_count"}, 32'(COUNT_O), 32'(sb.size()));
        chk({tag, "_ovf"},   32'(OVERFLOW_O), 32'(ovf_m));
        chk({tag, "_data"},  32'(DATA_O), head);
`ifdef MCP_RX_DROP_CNT_EN
        chk({tag, "_dropcnt"}, 32'(DROP_CNT_O), 32'(drop_m));
`endif
    endtask

    // One clock: drive inputs, update the model, pop-check the head word
    // against the scoreboard, clock, then check the visible state.
    task automatic step(input string tag, input logic sync, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
        bit pop_m;
        bit full_m;
        SYNC_I  = sync;
        DATA_I  = d;
        READY_I = rdy;
        CLEAR_I = clr;
        if (clr) begin
            sb.delete();
            ovf_m  = 1'b0;
            drop_m = 0;
        end else begin
            full_m = (sb.size() == DEPTH);
            pop_m  = (sb.size() != 0) && rdy;
            if (pop_m) begin
                chk({tag, "_pop"}, 32'(DATA_O), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (sync) begin
                if (!full_m || pop_m) begin
                    sb.push_back(d);
                end else begin
                    ovf_m = 1'b1;
                    if (drop_m < 65535) drop_m++;
                end
            end
        end
        @(posedge CLK_I);
        #1;
        SYNC_I  = 1'b0;
        READY_I = 1'b0;
        CLEAR_I = 1'b0;
        check_state(tag);
    endtask

    initial begin
        RST_NI  = 1'b0;
        DATA_I  = '0;
        SYNC_I  = 1'b0;
        CLEAR_I = 1'b0;
        READY_I = 1'b0;
        ovf_m   = 1'b0;
        drop_m  = 0;
        repeat (2) @(posedge CLK_I);
        #3;
        RST_NI = 1'b1;
        #1;
        check_state("reset");

        // Single word, fall-through latency, then pop.
        step("single_push", 1'b1, 5'h0A, 1'b0, 1'b0);
        chk("single_head", 32'(DATA_O), 32'h0A);
        step("single_pop", 1'b0, 5'h00, 1'b1, 1'b0);
        chk("single_empty", 32'(VALID_O), 32'd0);

        // Five pulses into a depth-4 FIFO with the consumer stalled.
        for (int i = 1; i <= 5; i++) step("fill5", 1'b1, WIDTH'(i), 1'b0, 1'b0);
        chk("fill5_count", 32'(COUNT_O), 32'd4);
        chk("fill5_ovf", 32'(OVERFLOW_O), 32'd1);
`ifdef MCP_RX_DROP_CNT_EN
        chk("fill5_dropcnt", 32'(DROP_CNT_O), 32'd1);
`endif
        step("stall", 1'b0, 5'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain5", 1'b0, 5'h00, 1'b1, 1'b0);
        step("clear_ovf", 1'b0, 5'h00, 1'b0, 1'b1);

        // Full FIFO with simultaneous push and pop: no overflow.
        for (int i = 1; i <= 4; i++) step("fill4", 1'b1, WIDTH'(i), 1'b0, 1'b0);
        step("full_pushpop", 1'b1, 5'h09, 1'b1, 1'b0);
        chk("full_pushpop_ovf", 32'(OVERFLOW_O), 32'd0);
        chk("full_pushpop_count", 32'(COUNT_O), 32'd4);
        for (int i = 0; i < 4; i++) step("drain_pp", 1'b0, 5'h00, 1'b1, 1'b0);

        // Streaming 0..31 with the consumer always ready: pointers wrap.
        for (int i = 0; i < 32; i++) begin
            step("stream", 1'b1, WIDTH'(i), 1'b1, 1'b0);
            chk("stream_count_le1", 32'(COUNT_O <= 1), 32'd1);
        end
        step("stream_tail", 1'b0, 5'h00, 1'b1, 1'b0);

        // Three words plus sticky overflow, then clear with a colliding pulse.
        for (int i = 0; i < 5; i++) step("ovf_fill", 1'b1, WIDTH'(5'h10 + i), 1'b0, 1'b0);
        step("ovf_pop1", 1'b0, 5'h00, 1'b1, 1'b0);
        chk("pre_clear_count", 32'(COUNT_O), 32'd3);
        chk("pre_clear_ovf", 32'(OVERFLOW_O), 32'd1);
        step("clear_sync", 1'b1, 5'h15, 1'b0, 1'b1);
        chk("clear_count", 32'(COUNT_O), 32'd0);
        chk("clear_ovf", 32'(OVERFLOW_O), 32'd0);
        step("post_clear", 1'b0, 5'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with two words stored.
        step("rst_fill", 1'b1, 5'h03, 1'b0, 1'b0);
        step("rst_fill", 1'b1, 5'h04, 1'b0, 1'b0);
        #2;
        RST_NI = 1'b0;
        #1;
        sb.delete();
        ovf_m  = 1'b0;
        drop_m = 0;
        chk("async_rst_valid", 32'(VALID_O), 32'd0);
        chk("async_rst_count", 32'(COUNT_O), 32'd0);
        SYNC_I = 1'b1;
        DATA_I = 5'h07;
        @(posedge CLK_I);
        #1;
        SYNC_I = 1'b0;
        check_state("in_reset");
        #2;
        RST_NI = 1'b1;
        #1;
        check_state("rst_release");
        step("post_rst_push", 1'b1, 5'h1F, 1'b0, 1'b0);
        chk("post_rst_head", 32'(DATA_O), 32'h1F);
        step("post_rst_pop", 1'b0, 5'h00, 1'b1, 1'b0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
